// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// Module   : config_pkg
// Purpose  : Shared types, widths and CRC helpers for the tile config loader.
// Revision : 1.0  initial release
// ============================================================================
package config_pkg;

    localparam int LE_CONFIG_WIDTH   = 5;
    localparam int SB_CONFIG_WIDTH   = 24;
    localparam int TILE_CONFIG_WIDTH = LE_CONFIG_WIDTH + SB_CONFIG_WIDTH;

    localparam int                   CRC_WIDTH = 16;
    localparam logic [CRC_WIDTH-1:0] CRC_POLY  = 16'h1021;
    localparam logic [CRC_WIDTH-1:0] CRC_INIT  = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CHECK  = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    // One MSB-first CRC-16-CCITT step for a single incoming bit.
    function automatic logic [CRC_WIDTH-1:0] crc16_step(input logic [CRC_WIDTH-1:0] crc,
                                                        input logic                 b);
        return {crc[CRC_WIDTH-2:0], 1'b0} ^ ((crc[CRC_WIDTH-1] ^ b) ? CRC_POLY : '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/config_crc16.sv
`default_nettype none
// ============================================================================
// Module   : config_crc16
// Purpose  : Serial CRC-16-CCITT accumulator, one bit per enabled cycle.
// Revision : 1.0  initial release
// ============================================================================
module config_crc16
    import config_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic                 bit_i,
    output logic [CRC_WIDTH-1:0] crc_o
);

    logic [CRC_WIDTH-1:0] crc_q;
    logic [CRC_WIDTH-1:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = CRC_INIT;
        end else if (en_i) begin
            crc_d = crc16_step(crc_q, bit_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// Module   : config_loader
// Purpose  : Serial-in shadow loader that commits a full tile image atomically.
//            Optional CRC-16 check of the image when CONFIG_LOADER_CRC_EN is set.
// Revision : 1.0  initial release
// ============================================================================
module config_loader
    import config_pkg::*;
#(
    parameter int NUM_TILES    = 2,
    parameter int CONFIG_WIDTH = TILE_CONFIG_WIDTH
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              bit_in,
    input  logic                              bit_valid,
    output logic                              bit_ready,
    output logic [NUM_TILES*CONFIG_WIDTH-1:0] config_out,
    output logic                              tile_enable,
    output logic                              busy,
    output logic                              done,
    output logic                              error
);

    localparam int TOTAL_BITS = NUM_TILES * CONFIG_WIDTH;
`ifdef CONFIG_LOADER_CRC_EN
    localparam int LOAD_BITS  = TOTAL_BITS + CRC_WIDTH;
`else
    localparam int LOAD_BITS  = TOTAL_BITS;
`endif
    localparam int               CNT_W    = $clog2(LOAD_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(TOTAL_BITS);

    state_t                state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [TOTAL_BITS-1:0] shadow_q,  shadow_d;
    logic [TOTAL_BITS-1:0] config_q,  config_d;
    logic                  tile_en_q, tile_en_d;
    logic                  done_q,    done_d;
    logic                  error_q,   error_d;
    logic                  xfer_w;
    logic                  data_bit_w;

    assign bit_ready  = (state_q == LOAD);
    // A start in the same cycle as a bit wins; that bit is dropped.
    assign xfer_w     = bit_valid && bit_ready && !start;
    assign data_bit_w = (cnt_q < CNT_DATA);

`ifdef CONFIG_LOADER_CRC_EN
    logic [CRC_WIDTH-1:0] crc_calc_w;
    logic [CRC_WIDTH-1:0] crc_rx_q, crc_rx_d;

    config_crc16 u_crc (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (start),
        .en_i    (xfer_w && data_bit_w),
        .bit_i   (bit_in),
        .crc_o   (crc_calc_w)
    );
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        config_d  = config_q;
        tile_en_d = tile_en_q;
        done_d    = 1'b0;
        error_d   = error_q;
`ifdef CONFIG_LOADER_CRC_EN
        crc_rx_d  = crc_rx_q;
`endif
        if (start) begin
            state_d   = LOAD;
            cnt_d     = '0;
            tile_en_d = 1'b0;
            error_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (xfer_w) begin
                        cnt_d = cnt_q + 1'b1;
                        if (data_bit_w) shadow_d = {shadow_q[TOTAL_BITS-2:0], bit_in};
`ifdef CONFIG_LOADER_CRC_EN
                        else crc_rx_d = {crc_rx_q[CRC_WIDTH-2:0], bit_in};
                        if (cnt_q == CNT_LAST) state_d = CHECK;
`else
                        if (cnt_q == CNT_LAST) state_d = COMMIT;
`endif
                    end
                end
`ifdef CONFIG_LOADER_CRC_EN
                CHECK: begin
                    if (crc_calc_w == crc_rx_q) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
`endif
                COMMIT: begin
                    // Image and enable change on the same edge: tiles never see a partial load.
                    state_d   = DONE;
                    config_d  = shadow_q;
                    tile_en_d = 1'b1;
                    done_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            shadow_q  <= '0;
            config_q  <= '0;
            tile_en_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
            crc_rx_q  <= '0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            config_q  <= config_d;
            tile_en_q <= tile_en_d;
            done_q    <= done_d;
            error_q   <= error_d;
`ifdef CONFIG_LOADER_CRC_EN
            crc_rx_q  <= crc_rx_d;
`endif
        end
    end

    assign config_out  = config_q;
    assign tile_enable = tile_en_q;
    assign done        = done_q;
    assign error       = error_q;
    assign busy        = (state_q == LOAD) || (state_q == CHECK) || (state_q == COMMIT);

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_loader
// Purpose  : Self-checking bench for config_loader (table + random loads).
// Revision : 1.0  initial release
// ============================================================================
module tb_config_loader;
    import config_pkg::*;

    localparam int NT = 2;
    localparam int TB = NT * TILE_CONFIG_WIDTH;
`ifdef CONFIG_LOADER_CRC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clock = 1'b0;
    logic          reset, start, bit_in, bit_valid;
    logic          bit_ready, tile_enable, busy, done, error;
    logic [TB-1:0] config_out;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [TB-1:0] exp_cfg;

    typedef struct {
        logic [TB-1:0] data;
        int            gap;
        int            restart_at;
        logic [TB-1:0] exp_cfg;
    } vec_t;

    always #5 clock = ~clock;

    config_loader #(.NUM_TILES(NT), .CONFIG_WIDTH(TILE_CONFIG_WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .config_out  (config_out),
        .tile_enable (tile_enable),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

`ifdef CONFIG_LOADER_CRC_EN
    function automatic logic [15:0] ref_crc(input logic [TB-1:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = TB - 1; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = (c << 1) ^ 16'h1021;
            else              c = c << 1;
        end
        return c;
    endfunction
`endif

    // Full load: start, optional garbage + restart, stream, then commit/error checks.
    task automatic do_load(input logic [TB-1:0] data, input int gap, input int restart_at,
                           input logic crc_bad, input logic [TB-1:0] expv, input string nm);
        logic          q[$];
        int            n, cyc;
        logic          v, stable;
        logic [TB-1:0] old;
        old = exp_cfg;
        for (int i = TB - 1; i >= 0; i--) q.push_back(data[i]);
`ifdef CONFIG_LOADER_CRC_EN
        begin
            logic [15:0] c;
            c = ref_crc(data);
            if (crc_bad) c[0] = ~c[0];
            for (int i = 15; i >= 0; i--) q.push_back(c[i]);
        end
`endif
        start = 1'b1; bit_valid = 1'b0;
        @(negedge clock);
        start = 1'b0;
        check({nm, ".ready"}, 64'(bit_ready), 64'd1);
        check({nm, ".en_drop"}, 64'(tile_enable), 64'd0);
        check({nm, ".err_clr"}, 64'(error), 64'd0);
        if (restart_at >= 0) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            repeat (restart_at) @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        n = 0; cyc = 0; stable = 1'b1;
        while (n < q.size() && cyc < 4000) begin
            v = (gap == 0) ? 1'b1 : (gap == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            bit_valid = v;
            bit_in    = v ? q[n] : 1'($urandom);
            if (bit_ready !== 1'b1 || busy !== 1'b1) stable = 1'b0;
            @(negedge clock);
            cyc++;
            if (v) n++;
            if (config_out !== old || tile_enable !== 1'b0 || done !== 1'b0) stable = 1'b0;
        end
        check({nm, ".stream"}, 64'(stable), 64'd1);
        // Junk on the bus after the final bit must be ignored.
        bit_valid = 1'b1; bit_in = 1'($urandom);
        check({nm, ".ready_drop"}, 64'(bit_ready), 64'd0);
        if (crc_bad) begin
            @(negedge clock);
            check({nm, ".err"}, {61'd0, error, tile_enable, done}, 64'b100);
            check({nm, ".cfg_kept"}, 64'(config_out), 64'(old));
            @(negedge clock);
            check({nm, ".no_done"}, {61'd0, error, tile_enable, done}, 64'b100);
        end else begin
            check({nm, ".pre_commit"}, {tile_enable, 64'(config_out)} == {1'b0, 64'(old)} ? 64'd1 : 64'd0, 64'd1);
            repeat (LAT - 1) @(negedge clock);
            check({nm, ".cfg"}, 64'(config_out), 64'(expv));
            check({nm, ".flags"}, {60'd0, done, tile_enable, busy, error}, 64'b1100);
            @(negedge clock);
            check({nm, ".pulse_end"}, {62'd0, done, tile_enable}, 64'b01);
            exp_cfg = expv;
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        vec_t        tbl[5];
        logic [63:0] r;
        logic [TB-1:0] d;

        reset = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; exp_cfg = '0;
        repeat (2) @(negedge clock);
        check("reset", {58'd0, bit_ready, tile_enable, busy, done, error, |config_out}, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        tbl[0] = '{58'h2AAAAAAAAAAAAAA, 0, -1, 58'h2AAAAAAAAAAAAAA};
        tbl[1] = '{58'h2AAAAAAAAAAAAAA, 1, -1, 58'h2AAAAAAAAAAAAAA};
        tbl[2] = '{58'h3FFFFFFFFFFFFFF, 0, -1, 58'h3FFFFFFFFFFFFFF};
        tbl[3] = '{58'h0,               0, 20, 58'h0};
        tbl[4] = '{58'h123456789ABCDEF, 2, TB - 1, 58'h123456789ABCDEF};

        do_load(tbl[0].data, tbl[0].gap, tbl[0].restart_at, 1'b0, tbl[0].exp_cfg, "vec0");

        // Reset in the middle of a load: outputs clear without a clock edge.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
        repeat (40) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset.cfg", 64'(config_out), 64'd0);
        check("midreset.flags", {59'd0, bit_ready, tile_enable, busy, done, error}, 64'd0);
        bit_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0; exp_cfg = '0;
        @(negedge clock);

        for (int i = 1; i < 5; i++) begin
            do_load(tbl[i].data, tbl[i].gap, tbl[i].restart_at, 1'b0, tbl[i].exp_cfg,
                    $sformatf("vec%0d", i));
        end

        for (int k = 0; k < 6; k++) begin
            r = {$urandom, $urandom};
            d = r[TB-1:0];
            do_load(d, int'($urandom_range(0, 2)),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TB - 1)) : -1,
                    1'b0, d, $sformatf("rnd%0d", k));
        end

`ifdef CONFIG_LOADER_CRC_EN
        r = {$urandom, $urandom};
        d = r[TB-1:0];
        do_load(d, 0, -1, 1'b1, exp_cfg, "crc_bad");
        r = {$urandom, $urandom};
        d = r[TB-1:0];
        do_load(d, 1, -1, 1'b0, d, "crc_recover");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/config_loader.md
Name: config_loader

Overview:
- Serial configuration writer that produces the parallel `config_in` words consumed by a row of logic tiles (29-bit word per tile: bits [4:0] logic element, [28:5] switchbox).
- Accepts a bitstream over a valid/ready handshake into a shadow shift register.
- Commits the complete image atomically to its outputs, then raises the tiles' enable.
- Tiles never observe a partially loaded configuration.

Parameters:
- NUM_TILES, 2, number of tiles fed by this loader.
- CONFIG_WIDTH, 29, config bits per tile.
- TOTAL_BITS, NUM_TILES*CONFIG_WIDTH, derived; not to be overridden.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load.
- bit_in  input  1  serial config bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  loader accepts bit_in this cycle.
- config_out  output  TOTAL_BITS  committed config; tile k gets [(k+1)*CONFIG_WIDTH-1 : k*CONFIG_WIDTH].
- tile_enable  output  1  drives tile `enable`; high only when a valid image is committed.
- busy  output  1  high in LOAD/CHECK/COMMIT.
- done  output  1  one-cycle pulse on commit.
- error  output  1  sticky CRC failure flag (feature only; tied 0 otherwise).

Behaviour:
- Reset values: config_out=0, tile_enable=0, bit_ready=0, busy=0, done=0, error=0; state=IDLE; bit counter=0; shadow=0.
- Reset asserted mid-load: discards all progress and drops tile_enable immediately (asynchronous).
- States and transitions:
  - IDLE: start -> LOAD.
  - LOAD: on exit, -> CHECK when the feature is compiled in, else -> COMMIT.
  - CHECK (feature only): -> COMMIT or ERROR.
  - COMMIT: -> DONE after one cycle.
  - DONE: start -> LOAD.
  - ERROR (feature only): start -> LOAD.
- Entering LOAD from any state:
  - clears the counter and error;
  - deasserts tile_enable in the same edge;
  - leaves config_out unchanged.
- LOAD:
  - bit_ready=1 combinationally from state.
  - A transfer occurs when bit_valid & bit_ready: shadow <= {shadow[TOTAL_BITS-2:0], bit_in}, counter+1.
  - First bit received ends at MSB of config_out (tile NUM_TILES-1, bit 28).
  - Counter width $clog2(TOTAL_BITS+1). LOAD exits on the edge that accepts bit number TOTAL_BITS; bit_ready=0 from the next cycle.
  - bit_valid with bit_ready=0 is ignored; no bit is lost or counted.
- start during LOAD/CHECK/COMMIT: restarts the load (counter cleared, shadow retained but overwritten). start in the same cycle as the final bit: restart wins; that bit is discarded.
- COMMIT: one cycle; config_out <= shadow.
- DONE:
  - Entered the cycle after COMMIT; the done pulse is asserted for exactly that one entry cycle.
  - tile_enable=1 throughout DONE. Latency from last accepted bit to tile_enable=1 is 2 cycles.
- busy=1 in LOAD, CHECK and COMMIT; 0 elsewhere.
- Gaps in bit_valid are permitted at any point; no timeout.

Optional Feature:
- Macro CONFIG_LOADER_CRC_EN.
- With it:
  - After TOTAL_BITS data bits, LOAD accepts 16 further bits as a CRC-16-CCITT value (poly 0x1021, init 0xFFFF, MSB-first, over data bits in arrival order).
  - CHECK compares the running CRC with the received value in 1 cycle.
  - Match -> COMMIT.
  - Mismatch -> ERROR: error=1, config_out and tile_enable unchanged (remain 0 if previously cleared by LOAD entry), stays until start or reset.
- Without it: no CHECK/ERROR states, exactly TOTAL_BITS bits per load, error tied 0.

Decomposition:
- Shared package config_pkg holds:
  - state enum (IDLE, LOAD, CHECK, COMMIT, DONE, ERROR);
  - LE_CONFIG_WIDTH=5, SB_CONFIG_WIDTH=24, TILE_CONFIG_WIDTH=29;
  - CRC_POLY=16'h1021, CRC_INIT=16'hFFFF.
- One sub-module: config_crc16, a serial CRC step unit (clear, enable, bit in, 16-bit crc out).

Test Plan:
- Reset, then start plus 58 bits alternating 1,0,... continuous -> bit_ready low after bit 58; config_out=58'h2AAAAAAAAAAAAAA two cycles later; done one-cycle pulse; tile_enable=1.
- Same 58 bits with bit_valid toggled every other cycle -> identical config_out; config_out stays 0 and tile_enable 0 until commit.
- Second load from DONE with all-ones stream -> tile_enable drops the cycle after start; config_out stays the old image until commit, then becomes all ones.
- start asserted after 20 bits, then 58 zeros -> config_out=0 committed; the first 20 bits have no effect.
- reset asserted at bit 40 -> all outputs 0 immediately; subsequent full load succeeds.
- With CONFIG_LOADER_CRC_EN: 58 bits followed by the correct CRC -> commit. Same stream with one CRC bit flipped -> error=1, no done pulse, tile_enable=0.
